// File: rtl/mmio_fabric.sv
// Memory-mapped I/O fabric: decodes the CPU address into NSLOT fixed-size windows.
// Fast slots complete in one cycle; WAIT_MASK slots go through an ack handshake with timeout.
module mmio_fabric #(
  parameter int                NSLOT      = 8,
  parameter int                ADDR_W     = 15,
  parameter int                SLOT_BITS  = 8,
  parameter int                DATA_W     = 8,
  parameter logic [NSLOT-1:0]  WAIT_MASK  = '0,
  parameter int                TIMEOUT    = 15,
  parameter logic [DATA_W-1:0] DEFAULT_RD = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    re,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       data_write,
  output logic [DATA_W-1:0]       data_read,
  output logic                    busy,
  output logic                    bus_err,
  output logic [NSLOT-1:0]        p_sel,
  output logic                    p_re,
  output logic                    p_we,
  output logic [SLOT_BITS-1:0]    p_addr,
  output logic [DATA_W-1:0]       p_wdata,
  input  logic [NSLOT*DATA_W-1:0] p_rdata,
  input  logic [NSLOT-1:0]        p_ack,
  output logic [1:0]              o_dbg_state
);

  localparam int IDX_W = ADDR_W - SLOT_BITS;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [NSLOT-1:0]     r_sel;
  logic                 r_re;
  logic                 r_we;
  logic [SLOT_BITS-1:0] r_off;
  logic [DATA_W-1:0]    r_wdata;
  logic [7:0]           r_cnt;
  logic [DATA_W-1:0]    r_data_read;
  logic                 r_bus_err;

  logic [IDX_W-1:0]  w_idx;
  logic [NSLOT-1:0]  w_hit;
  logic              w_mapped;
  logic              w_req;
  logic              w_rd;
  logic              w_wait;
  logic              w_fast;
  logic              w_ack;
  logic [DATA_W-1:0] w_cpu_rdata;
  logic [DATA_W-1:0] w_req_rdata;

  assign w_idx    = addr[ADDR_W-1:SLOT_BITS];
  assign w_req    = re | we;
  assign w_rd     = re & ~we;
  assign w_mapped = |w_hit;
  assign w_wait   = |(w_hit & WAIT_MASK);
  assign w_fast   = w_req & w_mapped & ~w_wait;
  assign w_ack    = |(p_ack & r_sel);

  // Slot decode and read muxes: one for the live CPU address, one for the registered request.
  always_comb begin
    w_hit       = '0;
    w_cpu_rdata = '0;
    w_req_rdata = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_hit[i]    = 1'b1;
        w_cpu_rdata = p_rdata[i*DATA_W +: DATA_W];
      end
      if (r_sel[i]) begin
        w_req_rdata = p_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // CPU handshake: while busy is high the CPU holds re/we/addr/data_write; an access
  // completes in the first cycle it is presented with busy low (DONE ignores the held request).
  always_comb begin
    p_sel   = '0;
    p_re    = 1'b0;
    p_we    = 1'b0;
    p_addr  = addr[SLOT_BITS-1:0];
    p_wdata = data_write;
    busy    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fast) begin
          p_sel = w_hit;
          p_re  = w_rd;
          p_we  = we;
        end
        busy = w_req & w_wait;
      end
      S_WAIT: begin
        p_sel   = r_sel;
        p_re    = r_re;
        p_we    = r_we;
        p_addr  = r_off;
        p_wdata = r_wdata;
        busy    = 1'b1;
      end
      default: begin
        p_addr  = r_off;
        p_wdata = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_re        <= 1'b0;
      r_we        <= 1'b0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_data_read <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (!w_mapped) begin
              if (w_rd) r_data_read <= DEFAULT_RD;
              r_bus_err <= 1'b1;
            end else if (w_wait) begin
              r_sel   <= w_hit;
              r_re    <= w_rd;
              r_we    <= we;
              r_off   <= addr[SLOT_BITS-1:0];
              r_wdata <= data_write;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else if (w_rd) begin
              r_data_read <= w_cpu_rdata;
            end
          end
        end
        S_WAIT: begin
          if (w_ack) begin
            if (r_re) r_data_read <= w_req_rdata;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            // Timed-out reads return the default byte; timed-out writes are simply dropped.
            if (r_re) r_data_read <= DEFAULT_RD;
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_read   = r_data_read;
  assign bus_err     = r_bus_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_fabric.sv
// Randomized scoreboard bench for mmio_fabric: the driver pushes expected {bus_err, data_read}
// per access, the monitor pops on each completed CPU access and checks strobes every cycle.
module tb_mmio_fabric;

  localparam int NSLOT     = 6;
  localparam int ADDR_W    = 15;
  localparam int SLOT_BITS = 8;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT   = 15;
  localparam logic [NSLOT-1:0]  WMASK = 6'b101000;
  localparam logic [DATA_W-1:0] DEF   = 8'hFF;

  logic                    clk;
  logic                    reset;
  logic                    re;
  logic                    we;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       data_write;
  logic [DATA_W-1:0]       data_read;
  logic                    busy;
  logic                    bus_err;
  logic [NSLOT-1:0]        p_sel;
  logic                    p_re;
  logic                    p_we;
  logic [SLOT_BITS-1:0]    p_addr;
  logic [DATA_W-1:0]       p_wdata;
  logic [NSLOT*DATA_W-1:0] p_rdata;
  logic [NSLOT-1:0]        p_ack;
  logic [1:0]              dbg_state;

  mmio_fabric #(
    .NSLOT(NSLOT), .ADDR_W(ADDR_W), .SLOT_BITS(SLOT_BITS), .DATA_W(DATA_W),
    .WAIT_MASK(WMASK), .TIMEOUT(TIMEOUT), .DEFAULT_RD(DEF)
  ) dut (
    .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .data_write(data_write),
    .data_read(data_read), .busy(busy), .bus_err(bus_err), .p_sel(p_sel), .p_re(p_re),
    .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ack(p_ack),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference state ----------------
  logic [DATA_W-1:0] slot_data [NSLOT];
  logic [DATA_W-1:0] model_dr;
  logic [8:0]        exp_q[$];
  int                checks;
  int                errors;

  logic [NSLOT-1:0]     cur_sel;
  logic                 cur_re;
  logic                 cur_we;
  logic [SLOT_BITS-1:0] cur_off;
  logic [DATA_W-1:0]    cur_wdata;
  int                   sel_seq;
  int                   sel_cyc;

  always_comb begin
    p_rdata = '0;
    for (int i = 0; i < NSLOT; i++) p_rdata[i*DATA_W +: DATA_W] = slot_data[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             pend;
  logic             prev_busy;
  logic [NSLOT-1:0] prev_sel;

  initial begin
    pend = 1'b0;
    prev_busy = 1'b0;
    prev_sel = '0;
    sel_seq = 0;
    sel_cyc = 0;
  end

  always @(negedge clk) begin
    logic accept;
    logic chk_now;
    logic [8:0] e;
    accept  = !reset && (re || we) && !busy;
    chk_now = pend || (accept && prev_busy);
    if (chk_now) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data_read", 32'(data_read), 32'(e[7:0]));
        chk("bus_err", 32'(bus_err), 32'(e[8]));
      end
    end else begin
      chk("bus_err_idle", 32'(bus_err), 32'd0);
    end
    pend      = accept && !prev_busy;
    prev_busy = busy && !reset;
    if (p_sel != '0 || p_re || p_we) begin
      chk("p_sel", 32'(p_sel), 32'(cur_sel));
      chk("p_re", 32'(p_re), 32'(cur_re));
      chk("p_we", 32'(p_we), 32'(cur_we));
      chk("p_addr", 32'(p_addr), 32'(cur_off));
      chk("p_wdata", 32'(p_wdata), 32'(cur_wdata));
    end
    if (p_sel != '0) begin
      sel_cyc++;
      if (prev_sel == '0) sel_seq++;
    end
    prev_sel = p_sel;
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input logic [ADDR_W-1:0] a, input logic wr, input logic rd,
                           input logic [DATA_W-1:0] wd, input int k);
    int idx;
    logic [NSLOT-1:0] wm;
    logic mapped, wslot, is_rd, exp_e, done;
    logic [DATA_W-1:0] exp_d;
    int n, busy_cnt, seq0, cyc0, exp_cyc;
    wm     = WMASK;
    idx    = int'(a[ADDR_W-1:SLOT_BITS]);
    mapped = (idx < NSLOT);
    wslot  = mapped ? wm[idx] : 1'b0;
    is_rd  = rd && !wr;
    n      = wslot ? ((k < TIMEOUT) ? k : TIMEOUT) : 0;
    exp_e  = !mapped || (wslot && k > TIMEOUT);
    if (is_rd) begin
      exp_d    = exp_e ? DEF : slot_data[idx];
      model_dr = exp_d;
    end else begin
      exp_d = model_dr;
    end
    exp_q.push_back({exp_e, exp_d});
    cur_sel   = mapped ? NSLOT'(1 << idx) : '0;
    cur_re    = mapped && is_rd;
    cur_we    = mapped && wr;
    cur_off   = a[SLOT_BITS-1:0];
    cur_wdata = wd;
    exp_cyc   = !mapped ? 0 : (wslot ? n : 1);
    seq0      = sel_seq;
    cyc0      = sel_cyc;
    addr       = a;
    data_write = wd;
    we         = wr;
    re         = rd;
    p_ack      = NSLOT'($urandom);
    busy_cnt   = 0;
    done       = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk);
        #1;
        p_ack = NSLOT'($urandom) & ~cur_sel;
        if (c + 1 == k) p_ack = p_ack | cur_sel;
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    re    = 1'b0;
    we    = 1'b0;
    p_ack = '0;
    chk("busy_cycles", 32'(busy_cnt), wslot ? 32'(n + 1) : 32'd0);
    chk("sel_cycles", 32'(sel_cyc - cyc0), 32'(exp_cyc));
    chk("sel_sequences", 32'(sel_seq - seq0), mapped ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_in_wait();
    addr       = {7'd3, 8'h44};
    data_write = 8'h9E;
    re         = 1'b1;
    we         = 1'b0;
    p_ack      = '0;
    cur_sel    = 6'b001000;
    cur_re     = 1'b1;
    cur_we     = 1'b0;
    cur_off    = 8'h44;
    cur_wdata  = 8'h9E;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    re    = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_p_sel", 32'(p_sel), 32'd0);
    chk("rst_p_re", 32'(p_re), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_data_read", 32'(data_read), 32'd0);
    model_dr = '0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    re = 1'b0;
    we = 1'b0;
    addr = '0;
    data_write = '0;
    p_ack = '0;
    model_dr = '0;
    cur_sel = '0;
    cur_re = 1'b0;
    cur_we = 1'b0;
    cur_off = '0;
    cur_wdata = '0;
    for (int i = 0; i < NSLOT; i++) slot_data[i] = DATA_W'($urandom);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_p_sel", 32'(p_sel), 32'd0);
    chk("reset_data_read", 32'(data_read), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;

    slot_data[0] = 8'h5A;
    do_access(15'h0012, 1'b0, 1'b1, 8'h00, 1);
    do_access(15'h0305, 1'b1, 1'b0, 8'hC3, 4);
    do_access(15'h0300, 1'b0, 1'b1, 8'h00, 99);
    do_access(15'h0700, 1'b0, 1'b1, 8'h00, 1);
    reset_in_wait();
    slot_data[0] = 8'hA7;
    do_access(15'h0034, 1'b0, 1'b1, 8'h00, 1);
    do_access(15'h0510, 1'b1, 1'b1, 8'h3C, 2);
    do_access(15'h0501, 1'b0, 1'b1, 8'h00, TIMEOUT);

    for (int t = 0; t < 80; t++) begin
      int op;
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < NSLOT; i++) slot_data[i] = DATA_W'($urandom);
      op = $urandom_range(0, 2);
      a  = {7'($urandom_range(0, 7)), 8'($urandom)};
      do_access(a, op != 0, op != 1, DATA_W'($urandom), $urandom_range(1, TIMEOUT + 2));
    end

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
